tinker_mem_ctrl: RTL and testbench

TINKER_MEM_CTRL -- requirements
Module: tinker_mem_ctrl

---
 rtl/tinker_mem_pkg.sv | 30 +++
 rtl/tinker_rr_arbiter.sv | 33 +++
 rtl/tinker_mem_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_tinker_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared definitions for the tinker memory controller.
// Holds the controller FSM state encoding, the request size encoding, default
// parameter values and a small helper that maps a size code to a byte count.
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    Size4B = 1'b0,
    Size8B = 1'b1
  } size_e;

  localparam int unsigned DefNumCh      = 2;
  localparam int unsigned DefDepthBytes = 524288;
  localparam int unsigned DefAddrW      = 64;
  localparam int unsigned DefLatency    = 2;

  // Wide enough for the largest supported latency (8).
  localparam int unsigned CntW  = 4;
  localparam int unsigned DataW = 64;

  function automatic logic [3:0] size_bytes(input logic size);
    return (size == Size8B) ? 4'd8 : 4'd4;
  endfunction

endpackage

// File: rtl/tinker_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   req     - per-channel request vector
//   pointer - index of the channel granted last; the search starts one above it
//   grant   - one-hot grant, all zero when no request is present
module tinker_rr_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int unsigned  NUM_CH = DefNumCh,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   pointer,
  output logic [NUM_CH-1:0] grant
);

  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((32'(pointer) + 32'd1 + i) % NUM_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tinker_mem_ctrl.sv
// Multi-channel byte-addressed memory controller.
// One transaction in flight; a round-robin arbiter picks among requesting
// channels while idle, and the response appears LATENCY cycles after accept.
// Ports:
//   clk, reset_n         - clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  - per-channel handshake, ready is one-hot or zero
//   req_we, req_size     - store/load and 4/8 byte size per channel
//   req_addr, req_wdata  - flattened per-channel byte address and store data
//   rsp_valid            - one-cycle response pulse
//   rsp_ch, rsp_rdata    - owning channel and load data (zero when not valid)
//   rsp_err              - access ran past the end of the array
module tinker_mem_ctrl
  import tinker_mem_pkg::*;
#(
  parameter int unsigned  NUM_CH      = DefNumCh,
  parameter int unsigned  DEPTH_BYTES = DefDepthBytes,
  parameter int unsigned  ADDR_W      = DefAddrW,
  parameter int unsigned  LATENCY     = DefLatency,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH-1:0]        req_size,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DataW-1:0]  req_wdata,
  output logic                     rsp_valid,
  output logic [CH_W-1:0]          rsp_ch,
  output logic [DataW-1:0]         rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned MemAw = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] ptr_q, ptr_d;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gnt_idx;
  logic              accept;

  // Winner's request fields, muxed straight from the inputs.
  logic              in_we;
  logic              in_size;
  logic [ADDR_W-1:0] in_addr;
  logic [DataW-1:0]  in_wdata;

  // Fields captured at acceptance.
  logic [CH_W-1:0]   lat_ch_q;
  logic              lat_we_q;
  logic              lat_size_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DataW-1:0]  lat_wdata_q;

  // Transaction being completed this cycle.
  logic [CH_W-1:0]   cur_ch;
  logic              cur_we;
  logic              cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [DataW-1:0]  cur_wdata;
  logic [3:0]        cur_nbytes;
  logic [ADDR_W:0]   cur_end;
  logic              cur_err;
  logic [MemAw-1:0]  cur_base;

  logic              enter_resp;
  logic [DataW-1:0]  rd_word;

  logic [7:0] mem [DEPTH_BYTES];

  logic              rsp_valid_q;
  logic [CH_W-1:0]   rsp_ch_q;
  logic [DataW-1:0]  rsp_rdata_q;
  logic              rsp_err_q;

  tinker_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .req     (req_valid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  always_comb begin
    gnt_idx  = '0;
    in_we    = 1'b0;
    in_size  = 1'b0;
    in_addr  = '0;
    in_wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = CH_W'(i);
        in_we    = req_we[i];
        in_size  = req_size[i];
        in_addr  = req_addr[i*ADDR_W +: ADDR_W];
        in_wdata = req_wdata[i*DataW +: DataW];
      end
    end
  end

  // Ready is also masked by reset so nothing looks accepted while held in reset.
  assign req_ready = (state_q == StIdle && reset_n) ? grant : '0;
  assign accept    = |req_ready;

  // With LATENCY = 1 the transaction completes at its own acceptance edge, so
  // the live request fields are used instead of the (not yet loaded) latches.
  always_comb begin
    if (state_q == StIdle) begin
      cur_ch    = gnt_idx;
      cur_we    = in_we;
      cur_size  = in_size;
      cur_addr  = in_addr;
      cur_wdata = in_wdata;
    end else begin
      cur_ch    = lat_ch_q;
      cur_we    = lat_we_q;
      cur_size  = lat_size_q;
      cur_addr  = lat_addr_q;
      cur_wdata = lat_wdata_q;
    end
  end

  assign cur_nbytes = size_bytes(cur_size);
  // One extra bit so addr + size cannot wrap.
  assign cur_end    = {1'b0, cur_addr} + (ADDR_W+1)'(cur_nbytes);
  assign cur_err    = cur_end > (ADDR_W+1)'(DEPTH_BYTES);
  assign cur_base   = cur_addr[MemAw-1:0];

  assign enter_resp = (state_q == StIdle && accept && LATENCY == 1) ||
                      (state_q == StWait && cnt_q == CntW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ptr_d = gnt_idx;
          if (LATENCY == 1) begin
            state_d = StResp;
            cnt_d   = '0;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= CH_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_ch_q    <= '0;
      lat_we_q    <= 1'b0;
      lat_size_q  <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else if (accept) begin
      lat_ch_q    <= gnt_idx;
      lat_we_q    <= in_we;
      lat_size_q  <= in_size;
      lat_addr_q  <= in_addr;
      lat_wdata_q <= in_wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < 32'(cur_nbytes)) begin
        rd_word[8*b +: 8] = mem[cur_base + MemAw'(b)];
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (b < 32'(cur_nbytes)) begin
          mem[cur_base + MemAw'(b)] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= enter_resp;
      rsp_ch_q    <= enter_resp ? cur_ch : '0;
      rsp_err_q   <= enter_resp && cur_err;
      rsp_rdata_q <= (enter_resp && !cur_err && !cur_we) ? rd_word : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tinker_mem_ctrl.sv
// Self-checking bench for tinker_mem_ctrl: a transaction-level model checks the
// LATENCY=2 instance every cycle; LATENCY=1 and LATENCY=8 instances get
// directed timing checks. Literal expectations pin the model.
module tb_tinker_mem_ctrl;

  localparam int              NCH   = 2;
  localparam int              LAT   = 2;
  localparam longint unsigned DEPTH = 524288;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    valid, valid_a, valid_b;
  logic [NCH-1:0]    ready, ready_a, ready_b;
  logic [NCH-1:0]    we, size;
  logic [NCH*64-1:0] addr, wdata;
  logic              rsp_valid, rsp_valid_a, rsp_valid_b;
  logic              rsp_ch, rsp_ch_a, rsp_ch_b;
  logic [63:0]       rsp_rdata, rsp_rdata_a, rsp_rdata_b;
  logic              rsp_err, rsp_err_a, rsp_err_b;

  tinker_mem_ctrl #(.NUM_CH(NCH), .DEPTH_BYTES(524288), .ADDR_W(64), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(valid), .req_ready(ready), .req_we(we),
    .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid),
    .rsp_ch(rsp_ch), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  tinker_mem_ctrl #(.NUM_CH(NCH), .DEPTH_BYTES(524288), .ADDR_W(64), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(valid_a), .req_ready(ready_a), .req_we(we),
    .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid_a),
    .rsp_ch(rsp_ch_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  tinker_mem_ctrl #(.NUM_CH(NCH), .DEPTH_BYTES(524288), .ADDR_W(64), .LATENCY(8)) u_dut_l8 (
    .clk(clk), .reset_n(reset_n), .req_valid(valid_b), .req_ready(ready_b), .req_we(we),
    .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid_b),
    .rsp_ch(rsp_ch_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the LATENCY=2 instance -------
  byte unsigned    mm [longint unsigned];
  int              m_since = 0;       // cycles since acceptance, 0 = idle
  int              m_last  = NCH - 1;
  int              p_ch;
  logic            p_we, p_size;
  longint unsigned p_addr;
  logic [63:0]     p_wdata;

  always @(negedge clk) begin
    logic [NCH-1:0]  e_ready;
    logic            e_v, e_err, oor, found;
    logic [63:0]     e_rd;
    int              e_ch, sb, c, win;
    e_ready = '0; e_v = 1'b0; e_err = 1'b0; e_rd = '0; e_ch = 0; oor = 1'b0;
    found = 1'b0; win = 0; sb = 4;
    if (!reset_n) begin
      m_since = 0;
      m_last  = NCH - 1;
    end else begin
      if (m_since == LAT) begin
        e_v   = 1'b1;
        e_ch  = p_ch;
        sb    = p_size ? 8 : 4;
        oor   = p_addr > DEPTH - longint'(sb);
        e_err = oor;
        if (!oor && !p_we)
          for (int b = 0; b < sb; b++)
            e_rd[8*b +: 8] = mm.exists(p_addr + b) ? mm[p_addr + b] : 8'h00;
      end
      if (m_since == 0)
        for (int i = 0; i < NCH; i++) begin
          c = (m_last + 1 + i) % NCH;
          if (!found && valid[c]) begin
            found = 1'b1;
            win = c;
            e_ready[c] = 1'b1;
          end
        end
    end
    chk("req_ready", ready, e_ready);
    chk("rsp_valid", rsp_valid, e_v);
    chk("rsp_ch", rsp_ch, e_ch);
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("rsp_err", rsp_err, e_err);
    if (reset_n) begin
      if (e_v) begin
        if (!oor && p_we)
          for (int b = 0; b < sb; b++) mm[p_addr + b] = p_wdata[8*b +: 8];
        m_since = 0;
      end else if (m_since > 0) begin
        m_since++;
      end else if (found) begin
        p_ch    = win;
        p_we    = we[win];
        p_size  = size[win];
        p_addr  = addr[win*64 +: 64];
        p_wdata = wdata[win*64 +: 64];
        m_last  = win;
        m_since = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic txn(input int ch, input logic w, input logic s, input longint unsigned a,
                     input logic [63:0] d, output logic [63:0] rd, output logic er,
                     output int rch);
    int n;
    @(posedge clk); #1;
    valid[ch] = 1'b1; we[ch] = w; size[ch] = s;
    addr[ch*64 +: 64] = a; wdata[ch*64 +: 64] = d;
    n = 0;
    @(negedge clk);
    while (!ready[ch] && n < 20) begin @(negedge clk); n++; end
    chk("accepted", ready[ch], 1);
    @(posedge clk); #1;
    // Scramble inputs to show the request was latched.
    valid[ch] = 1'b0; addr[ch*64 +: 64] = 64'hdead_0000; wdata[ch*64 +: 64] = '1;
    we[ch] = ~w; size[ch] = ~s;
    rd = '0; er = 1'b0; rch = -1; n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk("rsp_seen", rsp_valid, 1);
    chk("latency", n, LAT);
    if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; rch = int'(rsp_ch); end
  endtask

  task automatic lat_test(input int lat, input logic w, input longint unsigned a,
                          input logic [63:0] d, output logic [63:0] rd);
    int n;
    logic rdy, rv;
    @(posedge clk); #1;
    we[0] = w; size[0] = 1'b1; addr[63:0] = a; wdata[63:0] = d;
    if (lat == 1) valid_a[0] = 1'b1; else valid_b[0] = 1'b1;
    n = 0;
    @(negedge clk);
    rdy = (lat == 1) ? ready_a[0] : ready_b[0];
    while (!rdy && n < 20) begin
      @(negedge clk); n++;
      rdy = (lat == 1) ? ready_a[0] : ready_b[0];
    end
    chk($sformatf("l%0d_accept", lat), rdy, 1);
    @(posedge clk);
    rd = '0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      rv  = (lat == 1) ? rsp_valid_a : rsp_valid_b;
      rdy = (lat == 1) ? ready_a[0] : ready_b[0];
      chk($sformatf("l%0d_rsp_valid_c%0d", lat, k), rv, (k == lat));
      chk($sformatf("l%0d_ready_c%0d", lat, k), rdy, (k == lat + 1));
      if (k == lat) rd = (lat == 1) ? rsp_rdata_a : rsp_rdata_b;
    end
    @(posedge clk); #1;
    valid_a = '0; valid_b = '0;
    repeat (lat + 2) @(negedge clk);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    logic [63:0] rd;
    logic        er;
    int          rch, rspc;
    int          gseq[$];
    int          cseq[$];
    int          exp_g[4];
    exp_g = '{0, 1, 0, 1};
    valid = '0; valid_a = '0; valid_b = '0; we = '0; size = '0; addr = '0; wdata = '0;

    // Requests during reset must not be granted.
    repeat (2) @(posedge clk);
    #1 valid = 2'b11;
    @(negedge clk);
    chk("ready_in_reset", ready, 0);
    chk("rsp_valid_in_reset", rsp_valid, 0);
    @(posedge clk); #1 valid = '0; reset_n = 1'b1;

    // Round robin with both channels streaming stores.
    we = 2'b11; size = 2'b11;
    addr = {64'h300, 64'h200};
    wdata = {64'hbbbb_0000_bbbb_0001, 64'haaaa_0000_aaaa_0001};
    @(posedge clk); #1 valid = 2'b11;
    for (int k = 0; k < 60 && cseq.size() < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) cseq.push_back(int'(rsp_ch));
      if (ready != 0 && gseq.size() < 4) begin
        gseq.push_back(int'(ready[1]));
        if (gseq.size() == 4) begin @(posedge clk); #1 valid = '0; end
      end
    end
    chk("rr_grant_count", gseq.size(), 4);
    chk("rr_rsp_count", cseq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gseq.size()) chk($sformatf("rr_grant%0d", i), gseq[i], exp_g[i]);
      if (i < cseq.size()) chk($sformatf("rr_rsp_ch%0d", i), cseq[i], exp_g[i]);
    end
    repeat (3) @(negedge clk);

    // Store then loads, little-endian, unaligned.
    txn(0, 1'b1, 1'b1, 64'h100, 64'h1122334455667788, rd, er, rch);
    chk("st_rdata", rd, 0);
    chk("st_err", er, 0);
    txn(0, 1'b0, 1'b1, 64'h100, 64'h0, rd, er, rch);
    chk("ld8_rdata", rd, 64'h1122334455667788);
    txn(0, 1'b0, 1'b0, 64'h104, 64'h0, rd, er, rch);
    chk("ld4_rdata", rd, 64'h11223344);
    txn(1, 1'b0, 1'b0, 64'h103, 64'h0, rd, er, rch);
    chk("ld4_unaligned", rd, 64'h22334455);
    chk("ld4_unaligned_ch", rch, 1);

    // Out-of-range at the top of the array.
    txn(0, 1'b1, 1'b1, DEPTH - 8, 64'ha1a2a3a4a5a6a7a8, rd, er, rch);
    chk("top_store_err", er, 0);
    txn(0, 1'b0, 1'b1, DEPTH - 4, 64'h0, rd, er, rch);
    chk("oor_ld_err", er, 1);
    chk("oor_ld_rdata", rd, 0);
    txn(1, 1'b0, 1'b0, DEPTH - 4, 64'h0, rd, er, rch);
    chk("edge_ld_err", er, 0);
    chk("edge_ld_rdata", rd, 64'ha1a2a3a4);
    txn(0, 1'b1, 1'b1, DEPTH - 4, 64'hffff_ffff_ffff_ffff, rd, er, rch);
    chk("oor_st_err", er, 1);
    txn(0, 1'b1, 1'b1, 64'hffff_ffff_ffff_fffc, 64'h0, rd, er, rch);
    chk("wrap_st_err", er, 1);
    txn(0, 1'b0, 1'b1, DEPTH - 8, 64'h0, rd, er, rch);
    chk("neighbour_rdata", rd, 64'ha1a2a3a4a5a6a7a8);

    // Reset during WAIT drops a store.
    @(posedge clk); #1;
    valid[0] = 1'b1; we[0] = 1'b1; size[0] = 1'b1;
    addr[63:0] = 64'h100; wdata[63:0] = 64'hcafe_babe_dead_beef;
    rspc = 0;
    for (int k = 0; k < 20 && !ready[0]; k++) @(negedge clk);
    chk("rst_txn_accepted", ready[0], 1);
    @(posedge clk); #1 valid = '0; reset_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) rspc++;
      if (k == 1) begin @(posedge clk); #1 reset_n = 1'b1; end
    end
    chk("no_rsp_after_reset", rspc, 0);
    txn(0, 1'b0, 1'b1, 64'h100, 64'h0, rd, er, rch);
    chk("old_value_kept", rd, 64'h1122334455667788);

    // LATENCY 1 and 8 timing.
    lat_test(1, 1'b1, 64'h40, 64'h0123456789abcdef, rd);
    chk("l1_store_rdata", rd, 0);
    lat_test(1, 1'b0, 64'h40, 64'h0, rd);
    chk("l1_load_rdata", rd, 64'h0123456789abcdef);
    lat_test(8, 1'b1, 64'h48, 64'hfedcba9876543210, rd);
    chk("l8_store_rdata", rd, 0);
    lat_test(8, 1'b0, 64'h48, 64'h0, rd);
    chk("l8_load_rdata", rd, 64'hfedcba9876543210);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
